sphere_list_traverser: RTL and testbench

Issue side of the sphere intersection path: accepts one ray at a time and walks a sphere table of up to MAX_SPHERES entries. Each entry is read and issued, with the ray, to the pipelined sphere hit tester. The traverser collects the in-order tester responses and returns the closest positive hit as a single result. It sits between the ray dispatcher and the sphere hit tester, in parallel with the BVH voxel path.

---
 rtl/sphere_list_traverser.sv | 234 +++++++++++++++++++++++
 tb/tb_sphere_list_traverser.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sphere_list_traverser.sv
// sphere_list_traverser: walks the sphere table for one ray, issues every entry to the sphere hit tester, returns the closest positive hit.
// Latency: accept -> out_valid is N+2+L cycles (N live spheres, tester latency L), or 1 cycle for an empty table.
// Backpressure: in_ready low while a ray is in flight; result held until out_ready; tester side has no backpressure.
//
// Optional feature macro: SPHERE_TRAVERSE_ANY_HIT_EN -- when defined, in_any_hit stops the walk at the first qualified hit.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          ray request handshake; in_ray, in_any_hit, sphere_count sampled on accept
//   sph_rd_addr/sph_rd_data    sphere table read port, data valid one cycle after the address
//   tst_valid/tst_*            issue strobe and operands to the pipelined hit tester
//   rsp_valid/rsp_*            in-order tester responses (fixed latency L >= 1)
//   out_valid/out_ready/out_*  closest-hit result handshake

typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
} vec3_t;

typedef struct packed {
    vec3_t orig;
    vec3_t dir;
    vec3_t invdir;
} ray_t;

typedef struct packed {
    vec3_t              center;
    logic signed [31:0] radius;
} sphere_t;

module sphere_list_traverser #(
    parameter int MAX_SPHERES = 16,
    parameter int IDX_W       = $clog2(MAX_SPHERES)
) (
    input  logic                    clk,
    input  logic                    reset,
    // ray request
    input  logic                    in_valid,
    output logic                    in_ready,
    input  ray_t                    in_ray,
    input  logic                    in_any_hit,
    input  logic [IDX_W:0]          sphere_count,
    // sphere table read port
    output logic [IDX_W-1:0]        sph_rd_addr,
    input  sphere_t                 sph_rd_data,
    // issue to hit tester
    output logic                    tst_valid,
    output ray_t                    tst_ray,
    output sphere_t                 tst_sphere,
    output logic [IDX_W-1:0]        tst_index,
    // tester responses
    input  logic                    rsp_valid,
    input  logic                    rsp_hit,
    input  logic signed [31:0]      rsp_t,
    input  logic [IDX_W-1:0]        rsp_index,
    // result
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_hit,
    output logic signed [31:0]      out_t,
    output logic [IDX_W-1:0]        out_index
);

    localparam logic signed [31:0] T_MAX = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    ray_t                   ray_q;
    logic [IDX_W:0]         count_q;
    logic [IDX_W+1:0]       outstanding;
    logic [IDX_W+1:0]       outstanding_nxt;
    logic                   best_hit;
    logic signed [31:0]     best_t;
    logic [IDX_W-1:0]       best_idx;

    logic                   best_hit_nxt;
    logic signed [31:0]     best_t_nxt;
    logic [IDX_W-1:0]       best_idx_nxt;

    logic                   rsp_take;
    logic                   rsp_qual;
    logic                   best_upd;
    logic                   stop_issue;
    logic                   any_mode;
    logic                   drain_done;
    logic [IDX_W-1:0]       last_addr;

    // sph_rd_addr doubles as the read pointer; the table answers one cycle
    // later, so the data on sph_rd_data always belongs to tst_index.
    assign tst_ray    = ray_q;
    assign tst_sphere = sph_rd_data;

    assign last_addr = IDX_W'(count_q - (IDX_W+1)'(1));

    // A response only counts while something is actually outstanding; this
    // makes leftovers from an aborted ray (after reset) harmless.
    assign rsp_take = rsp_valid && (outstanding != '0);
    assign rsp_qual = rsp_take && rsp_hit && (rsp_t > 32'sd0);

`ifdef SPHERE_TRAVERSE_ANY_HIT_EN
    logic any_hit_q;
    assign any_mode = any_hit_q;
`else
    logic unused_any_hit;
    assign unused_any_hit = in_any_hit;
    assign any_mode       = 1'b0;
`endif

    // Closest-hit mode: strict less-than keeps the earlier (lower index) hit
    // on ties. Any-hit mode: only the first qualified hit is ever recorded.
    assign best_upd   = rsp_qual && (any_mode ? !best_hit : (rsp_t < best_t));
    assign stop_issue = any_mode && rsp_qual && !best_hit;

    always_comb begin
        best_hit_nxt = best_hit;
        best_t_nxt   = best_t;
        best_idx_nxt = best_idx;
        if (best_upd) begin
            best_hit_nxt = 1'b1;
            best_t_nxt   = rsp_t;
            best_idx_nxt = rsp_index;
        end
    end

    always_comb begin
        outstanding_nxt = outstanding;
        if (tst_valid && !rsp_take) begin
            outstanding_nxt = outstanding + (IDX_W+2)'(1);
        end else if (!tst_valid && rsp_take) begin
            outstanding_nxt = outstanding - (IDX_W+2)'(1);
        end
    end

    // Drain finishes on the edge that retires the last response, so the
    // result (including that response) is presented the following cycle.
    // A pending tst_valid always keeps outstanding_nxt non-zero.
    assign drain_done = (outstanding_nxt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_hit     <= 1'b0;
            out_t       <= T_MAX;
            out_index   <= '0;
            tst_valid   <= 1'b0;
            tst_index   <= '0;
            sph_rd_addr <= '0;
            outstanding <= '0;
            best_hit    <= 1'b0;
            best_t      <= T_MAX;
            best_idx    <= '0;
            ray_q       <= '0;
            count_q     <= '0;
`ifdef SPHERE_TRAVERSE_ANY_HIT_EN
            any_hit_q   <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding_nxt;
            best_hit    <= best_hit_nxt;
            best_t      <= best_t_nxt;
            best_idx    <= best_idx_nxt;
            tst_valid   <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ray_q       <= in_ray;
                        count_q     <= sphere_count;
`ifdef SPHERE_TRAVERSE_ANY_HIT_EN
                        any_hit_q   <= in_any_hit;
`endif
                        best_hit    <= 1'b0;
                        best_t      <= T_MAX;
                        best_idx    <= '0;
                        sph_rd_addr <= '0;
                        in_ready    <= 1'b0;
                        if (sphere_count == '0) begin
                            // Nothing to walk: report a miss straight away.
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_hit   <= 1'b0;
                            out_t     <= T_MAX;
                            out_index <= '0;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // The address driven this cycle is read now and issued
                    // next cycle, even when an any-hit stop arrives now.
                    tst_valid <= 1'b1;
                    tst_index <= sph_rd_addr;
                    if ((sph_rd_addr == last_addr) || stop_issue) begin
                        state <= DRAIN;
                    end else begin
                        sph_rd_addr <= sph_rd_addr + IDX_W'(1);
                    end
                end

                DRAIN: begin
                    if (drain_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_hit   <= best_hit_nxt;
                        out_t     <= best_t_nxt;
                        out_index <= best_idx_nxt;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sphere_list_traverser.sv
// tb_sphere_list_traverser: sphere table and fixed-latency tester models around the traverser, checked against a list-walk reference.
// Latency: not applicable (testbench).
// Backpressure: out_ready driven by the scenarios, including long holds in DONE.
module tb_sphere_list_traverser;

    localparam int MAX = 16;
    localparam int IW  = 4;
    localparam int ONE = 65536;
    localparam logic signed [31:0] T_MAX = 32'sh7FFF_FFFF;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    ray_t                 in_ray;
    logic                 in_any_hit;
    logic [IW:0]          sphere_count;
    logic [IW-1:0]        sph_rd_addr;
    sphere_t              sph_rd_data;
    logic                 tst_valid;
    ray_t                 tst_ray;
    sphere_t              tst_sphere;
    logic [IW-1:0]        tst_index;
    logic                 rsp_valid;
    logic                 rsp_hit;
    logic signed [31:0]   rsp_t;
    logic [IW-1:0]        rsp_index;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_hit;
    logic signed [31:0]   out_t;
    logic [IW-1:0]        out_index;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sphere_list_traverser #(.MAX_SPHERES(MAX)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ray(in_ray),
        .in_any_hit(in_any_hit), .sphere_count(sphere_count),
        .sph_rd_addr(sph_rd_addr), .sph_rd_data(sph_rd_data),
        .tst_valid(tst_valid), .tst_ray(tst_ray), .tst_sphere(tst_sphere), .tst_index(tst_index),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_t(rsp_t), .rsp_index(rsp_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_t(out_t), .out_index(out_index)
    );

    // Sphere table (1-cycle read) and per-sphere tester answers.
    sphere_t            mem     [MAX];
    logic               hit_tab [MAX];
    logic signed [31:0] t_tab   [MAX];

    always @(posedge clk) sph_rd_data <= mem[sph_rd_addr];

    // Tester: fixed latency lat, in order, unaware of traverser reset.
    int            lat = 3;
    logic          pv   [8];
    logic [IW-1:0] pidx [8];

    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) begin
            pv[i]   <= pv[i-1];
            pidx[i] <= pidx[i-1];
        end
        pv[0]   <= (tst_valid === 1'b1);
        pidx[0] <= tst_index;
    end

    always_comb begin
        rsp_valid = pv[lat-1];
        rsp_index = pidx[lat-1];
        rsp_hit   = hit_tab[pidx[lat-1]];
        rsp_t     = t_tab[pidx[lat-1]];
    end

    // Issue monitor: counts issues and flags wrong operands or order.
    ray_t cur_ray;
    int   issue_cnt;
    int   issue_bad;
    int   exp_issue_idx;

    always @(negedge clk) begin
        if (tst_valid === 1'b1) begin
            issue_cnt++;
            if (tst_sphere !== mem[tst_index] || tst_ray !== cur_ray || int'(tst_index) != exp_issue_idx)
                issue_bad++;
            exp_issue_idx++;
        end
    end

    // Reference: plain walk over the list in index order.
    task automatic ref_model(input int n, input bit any, output logic eh,
                             output logic signed [31:0] et, output int ei);
        bit first_only;
`ifdef SPHERE_TRAVERSE_ANY_HIT_EN
        first_only = any;
`else
        first_only = 1'b0;
`endif
        eh = 1'b0; et = T_MAX; ei = 0;
        for (int i = 0; i < n; i++) begin
            if (hit_tab[i] && t_tab[i] > 0) begin
                if (first_only) begin
                    eh = 1'b1; et = t_tab[i]; ei = i;
                    break;
                end
                if (t_tab[i] < et) begin
                    eh = 1'b1; et = t_tab[i]; ei = i;
                end
            end
        end
    endtask

    task automatic clear_tab();
        for (int i = 0; i < MAX; i++) begin
            mem[i]     = {$urandom, $urandom, $urandom, $urandom};
            hit_tab[i] = 1'b0;
            t_tab[i]   = 0;
        end
    endtask

    task automatic fill_random();
        int v;
        for (int i = 0; i < MAX; i++) begin
            mem[i]     = {$urandom, $urandom, $urandom, $urandom};
            hit_tab[i] = ($urandom_range(0, 9) < 4);
            v          = int'($urandom_range(0, 12)) - 3;
            t_tab[i]   = v * ONE;
        end
    endtask

    // Change tester latency only once its pipeline has fully emptied.
    task automatic set_lat(input int l);
        repeat (9) @(posedge clk);
        #1;
        lat = l;
    endtask

    task automatic start_ray(input int n, input bit any);
        cur_ray       = {$urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        in_ray        = cur_ray;
        in_any_hit    = any;
        sphere_count  = (IW+1)'(n);
        issue_cnt     = 0;
        issue_bad     = 0;
        exp_issue_idx = 0;
    endtask

    // Drives one ray to completion; returns what was observed.
    task automatic run_ray(input int n, input bit any, input int hold,
                           output logic g_hit, output logic signed [31:0] g_t, output int g_idx,
                           output int g_cyc, output bit g_stable, output bit g_post);
        start_ray(n, any);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g_cyc = 1;
        while (out_valid !== 1'b1 && g_cyc < 300) begin
            @(posedge clk); #1;
            g_cyc++;
        end
        g_hit    = out_hit;
        g_t      = out_t;
        g_idx    = int'(out_index);
        g_stable = (in_ready === 1'b0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_hit !== g_hit || out_t !== g_t ||
                int'(out_index) != g_idx || in_ready !== 1'b0)
                g_stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        g_post = (out_valid === 1'b0 && in_ready === 1'b1);
    endtask

    logic               g_hit;
    logic signed [31:0] g_t;
    int                 g_idx, g_cyc;
    bit                 g_stable, g_post;

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_ray = '0; in_any_hit = 1'b0; sphere_count = '0; cur_ray = '0;
        clear_tab();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || tst_valid !== 1'b0 || sph_rd_addr !== '0) begin
            failures++;
            $display("FAIL reset_values got in_ready=%b out_valid=%b tst_valid=%b addr=%0d exp 1 0 0 0",
                     in_ready, out_valid, tst_valid, sph_rd_addr);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_closest();
        set_lat(3);
        clear_tab();
        hit_tab[1] = 1'b1; t_tab[1] = 5 * ONE;
        hit_tab[3] = 1'b1; t_tab[3] = 2 * ONE;
        run_ray(4, 1'b0, 0, g_hit, g_t, g_idx, g_cyc, g_stable, g_post);
        checks++;
        if (g_hit !== 1'b1 || g_t !== 2 * ONE || g_idx != 3) begin
            failures++;
            $display("FAIL closest_result got hit=%b t=%h idx=%0d exp 1 %h 3", g_hit, g_t, g_idx, 2 * ONE);
        end
        checks++;
        if (g_cyc != 9) begin
            failures++;
            $display("FAIL closest_latency got=%0d exp=9", g_cyc);
        end
        checks++;
        if (issue_cnt != 4 || issue_bad != 0 || !g_stable || !g_post) begin
            failures++;
            $display("FAIL closest_issue got cnt=%0d bad=%0d stable=%0d post=%0d exp 4 0 1 1",
                     issue_cnt, issue_bad, g_stable, g_post);
        end
    endtask

    task automatic test_empty();
        clear_tab();
        hit_tab[0] = 1'b1; t_tab[0] = ONE;
        run_ray(0, 1'b0, 1, g_hit, g_t, g_idx, g_cyc, g_stable, g_post);
        checks++;
        if (g_hit !== 1'b0 || g_t !== T_MAX || g_idx != 0) begin
            failures++;
            $display("FAIL empty_result got hit=%b t=%h idx=%0d exp 0 7fffffff 0", g_hit, g_t, g_idx);
        end
        checks++;
        if (g_cyc != 1 || issue_cnt != 0) begin
            failures++;
            $display("FAIL empty_timing got cyc=%0d issues=%0d exp 1 0", g_cyc, issue_cnt);
        end
    endtask

    task automatic test_tie();
        set_lat(2);
        clear_tab();
        hit_tab[0] = 1'b1; t_tab[0] = 3 * ONE;
        hit_tab[1] = 1'b1; t_tab[1] = -ONE;
        hit_tab[2] = 1'b1; t_tab[2] = 3 * ONE;
        hit_tab[3] = 1'b1; t_tab[3] = 0;
        run_ray(4, 1'b0, 0, g_hit, g_t, g_idx, g_cyc, g_stable, g_post);
        checks++;
        if (g_hit !== 1'b1 || g_t !== 3 * ONE || g_idx != 0) begin
            failures++;
            $display("FAIL tie_result got hit=%b t=%h idx=%0d exp 1 %h 0", g_hit, g_t, g_idx, 3 * ONE);
        end
        checks++;
        if (g_cyc != 8) begin
            failures++;
            $display("FAIL tie_latency got=%0d exp=8", g_cyc);
        end
    endtask

    task automatic test_hold();
        logic               eh_a, eh_b;
        logic signed [31:0] et_a, et_b;
        int                 ei_a, ei_b, cyc;
        logic               h0;
        logic signed [31:0] t0;
        int                 i0;
        set_lat(1);
        fill_random();
        ref_model(2, 1'b0, eh_a, et_a, ei_a);
        ref_model(1, 1'b0, eh_b, et_b, ei_b);
        start_ray(2, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (out_hit !== eh_a || out_t !== et_a || int'(out_index) != ei_a || cyc != 5) begin
            failures++;
            $display("FAIL hold_first got hit=%b t=%h idx=%0d cyc=%0d exp %b %h %0d 5",
                     out_hit, out_t, out_index, cyc, eh_a, et_a, ei_a);
        end
        h0 = out_hit; t0 = out_t; i0 = int'(out_index);
        // A second ray waits at the input while the result is stalled.
        start_ray(1, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_hit !== h0 || out_t !== t0 || int'(out_index) != i0 ||
                in_ready !== 1'b0 || tst_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cycle %0d got ov=%b hit=%b t=%h idx=%0d ir=%b tv=%b exp 1 %b %h %0d 0 0",
                         k, out_valid, out_hit, out_t, out_index, in_ready, tst_valid, h0, t0, i0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got ov=%b ir=%b exp 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (out_hit !== eh_b || out_t !== et_b || int'(out_index) != ei_b || cyc != 4 || issue_cnt != 1) begin
            failures++;
            $display("FAIL hold_second got hit=%b t=%h idx=%0d cyc=%0d issues=%0d exp %b %h %0d 4 1",
                     out_hit, out_t, out_index, cyc, issue_cnt, eh_b, et_b, ei_b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_any_hit();
        set_lat(1);
        clear_tab();
        hit_tab[2] = 1'b1; t_tab[2] = 6 * ONE;
        hit_tab[3] = 1'b1; t_tab[3] = ONE;
        hit_tab[4] = 1'b1; t_tab[4] = ONE / 2;
        hit_tab[9] = 1'b1; t_tab[9] = ONE / 4;
        run_ray(16, 1'b1, 0, g_hit, g_t, g_idx, g_cyc, g_stable, g_post);
`ifdef SPHERE_TRAVERSE_ANY_HIT_EN
        checks++;
        if (g_hit !== 1'b1 || g_t !== 6 * ONE || g_idx != 2) begin
            failures++;
            $display("FAIL anyhit_result got hit=%b t=%h idx=%0d exp 1 %h 2", g_hit, g_t, g_idx, 6 * ONE);
        end
        checks++;
        if (issue_cnt < 3 || issue_cnt > 5 || issue_bad != 0) begin
            failures++;
            $display("FAIL anyhit_issues got cnt=%0d bad=%0d exp 3..5 0", issue_cnt, issue_bad);
        end
`else
        checks++;
        if (g_hit !== 1'b1 || g_t !== ONE / 4 || g_idx != 9) begin
            failures++;
            $display("FAIL anyhit_ignored got hit=%b t=%h idx=%0d exp 1 %h 9", g_hit, g_t, g_idx, ONE / 4);
        end
        checks++;
        if (issue_cnt != 16 || issue_bad != 0 || g_cyc != 19) begin
            failures++;
            $display("FAIL anyhit_ignored_walk got cnt=%0d bad=%0d cyc=%0d exp 16 0 19", issue_cnt, issue_bad, g_cyc);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit quiet;
        set_lat(3);
        clear_tab();
        for (int i = 0; i < 8; i++) begin
            hit_tab[i] = 1'b1;
            t_tab[i]   = (10 - i) * ONE;
        end
        start_ray(8, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || tst_valid !== 1'b0 || sph_rd_addr !== '0) begin
            failures++;
            $display("FAIL midreset_state got ir=%b ov=%b tv=%b addr=%0d exp 1 0 0 0",
                     in_ready, out_valid, tst_valid, sph_rd_addr);
        end
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || tst_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL midreset_quiet got activity after abort exp none");
        end
        clear_tab();
        hit_tab[0] = 1'b1; t_tab[0] = 4 * ONE;
        hit_tab[2] = 1'b1; t_tab[2] = 98304;
        run_ray(3, 1'b0, 0, g_hit, g_t, g_idx, g_cyc, g_stable, g_post);
        checks++;
        if (g_hit !== 1'b1 || g_t !== 98304 || g_idx != 2 || g_cyc != 8 || issue_cnt != 3) begin
            failures++;
            $display("FAIL midreset_next got hit=%b t=%h idx=%0d cyc=%0d issues=%0d exp 1 00018000 2 8 3",
                     g_hit, g_t, g_idx, g_cyc, issue_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 24; r++) begin
            int                 n, l, hold, ei, exp_lat;
            bit                 any, timed;
            logic               eh;
            logic signed [31:0] et;
            n    = $urandom_range(0, 16);
            l    = $urandom_range(1, 4);
            hold = $urandom_range(0, 2);
            any  = $urandom_range(0, 1);
            set_lat(l);
            fill_random();
            ref_model(n, any, eh, et, ei);
            run_ray(n, any, hold, g_hit, g_t, g_idx, g_cyc, g_stable, g_post);
            checks++;
            if (g_hit !== eh || g_t !== et || g_idx != ei) begin
                failures++;
                $display("FAIL rand%0d_result n=%0d L=%0d got hit=%b t=%h idx=%0d exp %b %h %0d",
                         r, n, l, g_hit, g_t, g_idx, eh, et, ei);
            end
`ifdef SPHERE_TRAVERSE_ANY_HIT_EN
            timed = !(any && eh);
`else
            timed = 1'b1;
`endif
            exp_lat = (n == 0) ? 1 : n + 2 + l;
            if (timed) begin
                checks++;
                if (g_cyc != exp_lat || issue_cnt != n) begin
                    failures++;
                    $display("FAIL rand%0d_timing got cyc=%0d issues=%0d exp %0d %0d",
                             r, g_cyc, issue_cnt, exp_lat, n);
                end
            end
            checks++;
            if (issue_bad != 0 || !g_stable || !g_post) begin
                failures++;
                $display("FAIL rand%0d_handshake got bad=%0d stable=%0d post=%0d exp 0 1 1",
                         r, issue_bad, g_stable, g_post);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_closest();
        test_empty();
        test_tie();
        test_hold();
        test_any_hit();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
